gray_counter: RTL
=================

# gray_counter

Registered N-bit Gray-code counter that directly feeds `gray_to_bin`. Its `g` output connects to the converter's `g` input, and the converter's `b` output must then equal the internal binary count. The counter supports enable, up/down direction and synchronous parallel load. At the counter's terminal value it either wraps or saturates, selected by parameter. Successive counts on `g` always differ in exactly one bit, which makes `g` safe to sample as a pointer or position code.

## Interface
- `N`, default 4: counter width in bits, N ≥ 2.
- `WRAP_EN`, default 1: 1 means the counter wraps modulo 2^N; 0 means it saturates at the terminal value.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: count enable; one step per cycle while high.
- `up`, input, 1: direction; 1 counts up, 0 counts down.
- `load`, input, 1: synchronous parallel load request.
- `load_val`, input, N: binary value to load.
- `g`, output, N: registered Gray code of the internal binary count.
- `wrap`, output, 1: registered one-cycle pulse marking a wrap-around step.
- `sat`, output, 1: registered one-cycle pulse marking an enabled step blocked at the terminal value (only when WRAP_EN=0).
- `tc`, output, 1: combinational terminal-count flag. It is 1 when `up`=1 and cnt = 2^N−1, or when `up`=0 and cnt = 0.

## Operation
- Internal state is an N-bit binary register `cnt` plus registered `g`, `wrap` and `sat`.
- Invariant: `g` = cnt ^ (cnt >> 1) at all times, including directly after reset and after a load.
- Priority each cycle is: `rst` > `load` > `en` > hold.
- Load (`load`=1): cnt ← `load_val`, `g` ← gray(`load_val`), `wrap` ← 0, `sat` ← 0. Load overrides `en` and ignores `up`.
- Enabled step, non-terminal (`en`=1, `tc`=0): cnt ← cnt ± 1, with the sign taken from `up`; `wrap` ← 0, `sat` ← 0.
- Enabled step, terminal, WRAP_EN=1: counting up goes cnt: 2^N−1 → 0; counting down goes cnt: 0 → 2^N−1. The step sets `wrap` ← 1 and `sat` ← 0.
- Enabled step, terminal, WRAP_EN=0: cnt holds, `wrap` ← 0, `sat` ← 1.
- Idle (`en`=0, `load`=0): cnt and `g` hold, `wrap` ← 0, `sat` ← 0.
- Direction may change on any cycle. The step taken uses `up` as sampled at that clock edge.
- Every enabled step that changes cnt changes exactly one bit of `g`, including wrap steps. A load may change several bits.
- `wrap` and `sat` are never both 1. `sat` is constant 0 when WRAP_EN=1, and `wrap` is constant 0 when WRAP_EN=0.
- Arithmetic is modulo 2^N on N bits, with no internal carry register. `tc` uses only `cnt` and the current `up`.

## Timing
- Reset: asserting `rst` immediately forces cnt=0, `g`=0, `wrap`=0 and `sat`=0, without waiting for a clock edge. After the counter resets to 0, `tc` = ~`up`.
- Reset during counting discards the count. Counting resumes from 0 on the first rising edge after `rst` deasserts with `en`=1.
- Latency is one cycle. A `load` or `en` sampled at edge k is visible on `g`, `wrap` and `sat` after edge k.
- `wrap` and `sat` are high for exactly the one cycle following the causing edge. They repeat every cycle while the blocked condition persists; for WRAP_EN=0 this happens with `en`=1 held at the terminal value.
- `tc` follows `up` combinationally within the same cycle, and follows `cnt` one cycle after each update.
- `g` is glitch-free because it is driven straight from flops.

## Test plan
- Reset and count up, N=4: after `rst` pulse, `g`=0000. Hold `en`=1, `up`=1 for 16 cycles. `g` must step 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then back to 0000. `wrap`=1 only in the cycle after 1000→0000, and every transition changes exactly one bit.
- Down wrap: from reset, `en`=1, `up`=0 for one cycle gives `g`=1000 and `wrap`=1. The next down step gives `g`=1001.
- Load priority: with cnt=3, apply `load`=1, `load_val`=0101 and `en`=1 together. Next cycle `g`=0111; one up step later `g`=0101.
- Saturation, WRAP_EN=0: load 1111 (giving `g`=1000), then apply `en`=1, `up`=1 for 3 cycles. `g` must stay 1000, with `sat`=1 each cycle, `wrap`=0 and `tc`=1. Switching `up`=0 drops `tc` immediately, and the next step gives `g`=1001.
- Asynchronous reset during counting: at cnt=9, assert `rst` between clock edges. `g` must go to 0000 before the next edge, and counting resumes 0001 after release.
- Chained with `gray_to_bin` (N=4 and N=8): random `en`, `up` and `load` for 1000 cycles. The converter's `b` must match a reference binary model every cycle.

Source files
------------

// File: rtl/gray_counter.sv
// ============================================================================
// gray_counter : N-bit Gray-code counter (enable, up/down, load, wrap/saturate)
//                plus gray_to_bin converter used to recover the binary count.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module gray_counter #(
  parameter int N       = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] g,
  output logic         wrap,
  output logic         sat,
  output logic         tc
);

  logic [N-1:0] cnt;
  logic [N-1:0] cnt_step;

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] v);
    return v ^ (v >> 1);
  endfunction

  assign tc       = up ? (cnt == {N{1'b1}}) : (cnt == {N{1'b0}});
  // Modulo-2^N step: at the terminal value this lands exactly on the wrap target.
  assign cnt_step = up ? cnt + {{(N-1){1'b0}}, 1'b1} : cnt - {{(N-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      g    <= '0;
      wrap <= 1'b0;
      sat  <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      g    <= to_gray(load_val);
      wrap <= 1'b0;
      sat  <= 1'b0;
    end else if (en && tc && !WRAP_EN) begin
      wrap <= 1'b0;
      sat  <= 1'b1;
    end else if (en) begin
      cnt  <= cnt_step;
      g    <= to_gray(cnt_step);
      wrap <= tc;
      sat  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      sat  <= 1'b0;
    end
  end

endmodule

module gray_to_bin #(
  parameter int N = 4
) (
  input  logic [N-1:0] g,
  output logic [N-1:0] b
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    b = '0;
    for (int i = 0; i < N; i++) begin
      b[i] = ^(g >> i);
    end
  end

endmodule

`default_nettype wire
